// File: rtl/candy_if.sv
// Key and display/dispense signal bundle for the candy vending machine.
interface candy_if;
  logic [3:0] key_in;
  logic [7:0] display_column;
  logic [7:0] out;
  logic       candy;
  logic [2:0] change_beg;
  logic       change_obeg;
  logic [2:0] col;

  modport master (
    output key_in,
    input  display_column, out, candy, change_beg, change_obeg, col
  );

  modport slave (
    input  key_in,
    output display_column, out, candy, change_beg, change_obeg, col
  );
endinterface

// File: rtl/candy_top.sv
// Candy vending machine: coin/buy/return key handling, balance keeping and
// a multiplexed 8-digit seven-segment balance display.
module candy_top #(
  parameter int unsigned PRICE    = 2,
  parameter int unsigned MAX_BAL  = 9,
  parameter int unsigned SCAN_DIV = 16
) (
  input logic  clk,
  input logic  reset,
  candy_if.slave bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [4:0]    MAX5      = 5'(MAX_BAL);
  localparam logic [3:0]    PRICE4    = 4'(PRICE);

  logic [3:0]    bal;
  logic [3:0]    key_prev;
  logic          armed;
  logic [CW-1:0] scan_cnt;
  logic [2:0]    col_q;
  logic [7:0]    dcol_q;
  logic [7:0]    seg_q;
  logic          candy_q;
  logic [2:0]    beg_q;
  logic          obeg_q;

  logic [3:0] press;
  logic       advance;
  logic [2:0] col_n;
  logic [3:0] digit;
  logic       blank;
  logic [7:0] seg_n;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // The first clock after reset only captures key history, so a key held
  // through reset release is not seen as a fresh press.
  always_comb begin
    press = armed ? (bus.key_in & ~key_prev) : '0;
  end

  always_comb begin
    advance = (scan_cnt == SCAN_LAST);
    col_n   = advance ? col_q + 3'd1 : col_q;
    digit   = '0;
    blank   = 1'b0;
    case (col_n)
      3'd0, 3'd1: digit = '0;
      3'd2:       digit = bal;
      default:    blank = 1'b1;
    endcase
    seg_n = blank ? 8'h00 : seg7(digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bal      <= '0;
      key_prev <= '0;
      armed    <= 1'b0;
      scan_cnt <= '0;
      col_q    <= '0;
      dcol_q   <= 8'hFE;
      seg_q    <= 8'h3F;
      candy_q  <= 1'b0;
      beg_q    <= '0;
      obeg_q   <= 1'b0;
    end else begin
      armed    <= 1'b1;
      key_prev <= bus.key_in;
      candy_q  <= 1'b0;
      beg_q    <= '0;
      obeg_q   <= 1'b0;
      if (press[2]) begin
        if (bal != '0) begin
          obeg_q <= (bal >= 4'd5);
          beg_q  <= 3'(bal % 4'd5);
          bal    <= '0;
        end
      end else if (press[3]) begin
        if (bal >= PRICE4) begin
          candy_q <= 1'b1;
          bal     <= bal - PRICE4;
        end
      end else if (press[1]) begin
        if (({1'b0, bal} + 5'd5) <= MAX5) bal <= bal + 4'd5;
      end else if (press[0]) begin
        if (({1'b0, bal} + 5'd1) <= MAX5) bal <= bal + 4'd1;
      end

      scan_cnt <= advance ? '0 : scan_cnt + 1'b1;
      col_q    <= col_n;
      dcol_q   <= ~(8'd1 << col_n);
      seg_q    <= seg_n;
    end
  end

  assign bus.col            = col_q;
  assign bus.display_column = dcol_q;
  assign bus.out            = seg_q;
  assign bus.candy          = candy_q;
  assign bus.change_beg     = beg_q;
  assign bus.change_obeg    = obeg_q;

endmodule

// File: tb/tb_candy_top.sv
// Self-checking bench for candy_top: directed scenarios plus random key
// traffic, compared every clock against a rule-level vending model.
module tb_candy_top;

  localparam int unsigned PRICE   = 2;
  localparam int unsigned MAX_BAL = 9;
  localparam int unsigned DIV_A   = 1;
  localparam int unsigned DIV_B   = 3;

  logic clk;
  logic reset;

  candy_if bus_a ();
  candy_if bus_b ();

  candy_top #(.PRICE(PRICE), .MAX_BAL(MAX_BAL), .SCAN_DIV(DIV_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave)
  );
  candy_top #(.PRICE(PRICE), .MAX_BAL(MAX_BAL), .SCAN_DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  // Reference model state
  int unsigned m_bal;
  logic [3:0]  m_prev;
  bit          m_armed;
  int unsigned m_edges;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int unsigned c, input int unsigned b);
    if (c < 2) return seg_tab[0];
    if (c == 2) return seg_tab[b];
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_bal   = 0;
    m_prev  = '0;
    m_armed = 0;
    m_edges = 0;
  endtask

  task automatic chk_reset_values();
    chk("rst_col_a",  8'(bus_a.col), 8'h00);
    chk("rst_dcol_a", bus_a.display_column, 8'hFE);
    chk("rst_out_a",  bus_a.out, 8'h3F);
    chk("rst_candy",  8'(bus_a.candy), 8'h00);
    chk("rst_beg",    8'(bus_a.change_beg), 8'h00);
    chk("rst_obeg",   8'(bus_a.change_obeg), 8'h00);
    chk("rst_col_b",  8'(bus_b.col), 8'h00);
    chk("rst_out_b",  bus_b.out, 8'h3F);
  endtask

  // Apply one key pattern for one clock, advance the model, compare everything.
  task automatic step(input logic [3:0] k);
    logic [3:0]  pr;
    int unsigned old_bal;
    int unsigned ca, cb;
    logic        e_candy, e_obeg;
    logic [2:0]  e_beg;
    bus_a.key_in = k;
    bus_b.key_in = k;
    @(posedge clk);
    #1;
    pr      = m_armed ? (k & ~m_prev) : 4'b0000;
    m_prev  = k;
    m_armed = 1;
    m_edges++;
    old_bal = m_bal;
    e_candy = 0;
    e_obeg  = 0;
    e_beg   = '0;
    if (pr[2]) begin
      if (m_bal > 0) begin
        e_obeg = (m_bal >= 5);
        e_beg  = 3'(m_bal % 5);
        m_bal  = 0;
      end
    end else if (pr[3]) begin
      if (m_bal >= PRICE) begin
        e_candy = 1;
        m_bal   = m_bal - PRICE;
      end
    end else if (pr[1]) begin
      if (m_bal + 5 <= MAX_BAL) m_bal = m_bal + 5;
    end else if (pr[0]) begin
      if (m_bal + 1 <= MAX_BAL) m_bal = m_bal + 1;
    end
    ca = (m_edges / DIV_A) % 8;
    cb = (m_edges / DIV_B) % 8;
    chk("candy_a", 8'(bus_a.candy), 8'(e_candy));
    chk("beg_a",   8'(bus_a.change_beg), 8'(e_beg));
    chk("obeg_a",  8'(bus_a.change_obeg), 8'(e_obeg));
    chk("col_a",   8'(bus_a.col), 8'(ca));
    chk("dcol_a",  bus_a.display_column, ~(8'd1 << ca));
    chk("out_a",   bus_a.out, exp_seg(ca, old_bal));
    chk("candy_b", 8'(bus_b.candy), 8'(e_candy));
    chk("col_b",   8'(bus_b.col), 8'(cb));
    chk("dcol_b",  bus_b.display_column, ~(8'd1 << cb));
    chk("out_b",   bus_b.out, exp_seg(cb, old_bal));
  endtask

  task automatic press(input logic [3:0] k);
    step(k);
    step(4'b0000);
  endtask

  initial begin
    logic [3:0] k;
    reset        = 1'b0;
    bus_a.key_in = '0;
    bus_b.key_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_reset_values();
    @(negedge clk);
    reset = 1'b1;

    // two 100 coins then buy
    step(4'b0000);
    press(4'b0001);
    press(4'b0001);
    press(4'b1000);

    // 500, buy, return -> 3 coins of 100
    press(4'b0010);
    press(4'b1000);
    press(4'b0100);

    // over-limit coins are refused
    press(4'b0010);
    press(4'b0010);
    repeat (5) press(4'b0001);
    press(4'b0100);

    // buy and coin together with balance 1
    press(4'b0001);
    press(4'b1001);
    step(4'b0000);

    // balance 2, one full scan sweep
    press(4'b0001);
    repeat (10) step(4'b0000);

    // held key: one action only
    step(4'b0001);
    repeat (4) step(4'b0001);
    step(4'b0000);
    press(4'b0100);

    // reset mid-operation with a key held through release
    press(4'b0010);
    bus_a.key_in = 4'b0001;
    bus_b.key_in = 4'b0001;
    #2;
    reset = 1'b0;
    #2;
    chk_reset_values();
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(4'b0001);
    step(4'b0000);
    press(4'b0001);
    press(4'b0100);

    // random key traffic
    for (int i = 0; i < 400; i++) begin
      k = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) k = 4'b0000;
      step(k);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/candy_top.md
CANDY_TOP -- requirements
Module: candy_top

Interface
REQ-001 SHALL have parameter PRICE, default 2, candy price in units of 100.
REQ-002 SHALL have parameter MAX_BAL, default 9, maximum balance in units of 100 (900).
REQ-003 SHALL have parameter SCAN_DIV, default 16, clocks per display digit (>=1).
REQ-004 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port key_in  input  4  keys, active-high:
- bit0 = insert 100
- bit1 = insert 500
- bit2 = return change
- bit3 = buy candy
REQ-007 SHALL have port display_column  output  8  digit enable, active-low one-hot.
REQ-008 SHALL have port out  output  8  segments {dp,g,f,e,d,c,b,a}, active-high.
REQ-009 SHALL have port candy  output  1  one-cycle dispense pulse.
REQ-010 SHALL have port change_beg  output  3  count of 100 coins returned, valid during the return pulse cycle.
REQ-011 SHALL have port change_obeg  output  1  one 500 coin returned, valid during the return pulse cycle.
REQ-012 SHALL have port col  output  3  index of the digit currently driven.

Function
REQ-013 SHALL sample key_in each clock, register the previous sample, and detect a press as sampled=1 with previous=0 (rising edge only); a held key SHALL act once.
REQ-014 SHALL keep balance as a 4-bit count of 100 units, range 0..MAX_BAL.
REQ-015 SHALL process at most one action per clock, priority return > buy > 500 > 100; lower-priority presses in the same cycle SHALL be discarded.
REQ-016 Insert 100 SHALL add 1 if balance+1<=MAX_BAL, else the coin is ignored and balance is unchanged.
REQ-017 Insert 500 SHALL add 5 if balance+5<=MAX_BAL, else the coin is ignored and balance is unchanged.
REQ-018 Buy SHALL, if balance>=PRICE:
- assert candy for exactly one clock in the cycle after the press is detected
- subtract PRICE from balance
REQ-019 Buy with balance<PRICE SHALL be ignored, with no pulse.
REQ-020 Return with balance>0 SHALL, for exactly one clock:
- drive change_obeg = (balance>=5)
- drive change_beg = balance mod 5
- then set balance to 0
REQ-021 Return with balance=0 SHALL be ignored and outputs SHALL stay 0.
REQ-022 change_beg and change_obeg SHALL be 0 outside the return pulse cycle.
REQ-023 Display SHALL show the balance as a decimal number in units of 1 (e.g. 200):
- digit 0 (rightmost) = '0'
- digit 1 = '0'
- digit 2 = balance
- digits 3..7 blank (out=0x00)
- if balance=0, digit 2 shows '0' (display "000")
REQ-024 Segment codes SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F; dp SHALL always be 0.
REQ-025 Display scan SHALL behave as follows:
- a counter advances col by 1 (mod 8) every SCAN_DIV clocks
- display_column SHALL equal ~(1<<col)
- out SHALL be the segment code for digit col, registered and aligned with col/display_column.

Reset
REQ-026 While reset=0, asynchronously SHALL set:
- balance=0, key history=0, scan counter=0
- col=0, display_column=8'hFE, out=0x3F
- candy=0, change_beg=0, change_obeg=0
REQ-027 Reset asserted mid-operation SHALL discard the balance without issuing change.
REQ-028 Keys held through reset release SHALL NOT register a press until released and pressed again.

Verification
REQ-029 SHALL cover: reset low -> all outputs at REQ-026 values, balance 0.
REQ-030 SHALL cover: two separate bit0 pulses then bit3 press -> balance 1, 2, then candy=1 for one cycle, balance 0.
REQ-031 SHALL cover: bit1 press, bit3 press, bit2 press -> candy pulse, then change_obeg=0 and change_beg=3 for one cycle, balance 0.
REQ-032 SHALL cover: bit1 twice -> second coin ignored, balance 5; then bit0 x4 -> balance 9; further bit0 ignored.
REQ-033 SHALL cover: bit3 and bit0 pressed in the same cycle with balance 1 -> buy fails, coin discarded, balance stays 1, no candy.
REQ-034 SHALL cover: balance 2 with SCAN_DIV=1 -> over 8 clocks, col steps 0..7, out sequence 0x3F, 0x3F, 0x5B, then 0x00 x5, display_column one-hot low.
